// File: rtl/game_state_core.sv
// game_state_core
// Game-flow controller for a timed, three-stage game. Commands come in as a
// 4-bit code plus a strobe. The block tracks game state, stage, lives and
// score, and runs a one-second countdown timer.
//
// Ports
//   clk_1mhz       in   1   system clock (CLK_HZ cycles per timer second)
//   rst            in   1   asynchronous active-high reset
//   flag           in   4   command code, captured alongside trig
//   trig           in   1   command strobe, only a rising edge is a request
//   done           out  1   one-cycle pulse for an accepted command
//   sec_posedge    out  1   one-cycle pulse on every timer second tick
//   timer_running  out  1   countdown active
//   timer          out  7   seconds remaining
//   state          out  3   0 READY, 1 PLAYING, 3 GAME_OVER, 4 STAGE_CLEAR, 5 GAME_CLEAR
//   stage          out  2   current stage, 1..3
//   lives          out  2   remaining lives, 0..3
//   score          out  10  score, 0..999
module game_state_core #(
    parameter int unsigned CLK_HZ     = 1000000,
    parameter int unsigned READY_SEC  = 3,
    parameter int unsigned STAGE1_SEC = 30,
    parameter int unsigned STAGE2_SEC = 25,
    parameter int unsigned STAGE3_SEC = 20
) (
    input  logic       clk_1mhz,
    input  logic       rst,
    input  logic [3:0] flag,
    input  logic       trig,
    output logic       done,
    output logic       sec_posedge,
    output logic       timer_running,
    output logic [6:0] timer,
    output logic [2:0] state,
    output logic [1:0] stage,
    output logic [1:0] lives,
    output logic [9:0] score
);

    localparam int unsigned PRESC_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned SCORE_MAX = 999;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
    localparam logic [6:0]         READY_T    = 7'(READY_SEC);
    localparam logic [6:0]         STAGE1_T   = 7'(STAGE1_SEC);
    localparam logic [6:0]         STAGE2_T   = 7'(STAGE2_SEC);
    localparam logic [6:0]         STAGE3_T   = 7'(STAGE3_SEC);

    localparam logic [3:0] CMD_START = 4'b0101;
    localparam logic [3:0] CMD_PLAY  = 4'b1010;
    localparam logic [3:0] CMD_HIT   = 4'b0001;
    localparam logic [3:0] CMD_MISS  = 4'b0010;
    localparam logic [3:0] CMD_NEXT  = 4'b1100;
    localparam logic [3:0] CMD_WIN   = 4'b1110;
    localparam logic [3:0] CMD_LOSE  = 4'b1101;
    localparam logic [3:0] CMD_BACK  = 4'b1000;

    typedef enum logic [2:0] {
        ST_READY       = 3'd0,
        ST_PLAYING     = 3'd1,
        ST_GAME_OVER   = 3'd3,
        ST_STAGE_CLEAR = 3'd4,
        ST_GAME_CLEAR  = 3'd5
    } game_state_t;

    game_state_t        st;
    logic               trig_s;
    logic               trig_q;
    logic [3:0]         flag_s;
    logic [PRESC_W-1:0] presc;

    logic        trig_rise;
    logic        cmd_ok;
    logic        sec_wrap;
    logic [6:0]  stage_time;
    logic [10:0] score_sum;
    logic [9:0]  score_next;

    assign state     = st;
    assign trig_rise = trig_s & ~trig_q;
    assign sec_wrap  = timer_running && (presc == PRESC_LAST);

    // Command legality: a request only counts in the states that define it.
    always_comb begin
        cmd_ok = 1'b0;
        if (trig_rise) begin
            case (flag_s)
                CMD_START: cmd_ok = (st == ST_READY) && (timer != 7'd0);
                CMD_PLAY:  cmd_ok = (st == ST_READY) && !timer_running;
                CMD_HIT,
                CMD_MISS:  cmd_ok = (st == ST_PLAYING) && (lives != 2'd0);
                CMD_NEXT,
                CMD_WIN,
                CMD_LOSE:  cmd_ok = (st == ST_PLAYING);
                CMD_BACK:  cmd_ok = (st == ST_STAGE_CLEAR) || (st == ST_GAME_OVER) ||
                                    (st == ST_GAME_CLEAR);
                default:   cmd_ok = 1'b0;
            endcase
        end
    end

    // Play time for the current stage.
    always_comb begin
        case (stage)
            2'd2:    stage_time = STAGE2_T;
            2'd3:    stage_time = STAGE3_T;
            default: stage_time = STAGE1_T;
        endcase
    end

    // Saturating score add; the 11-bit sum cannot overflow (999 + 3).
    always_comb begin
        score_sum  = 11'(score) + 11'(stage);
        score_next = (score_sum > 11'(SCORE_MAX)) ? 10'(SCORE_MAX) : score_sum[9:0];
    end

    // Game state, timer and strobe handling.
    always_ff @(posedge clk_1mhz or posedge rst) begin
        if (rst) begin
            st            <= ST_READY;
            stage         <= 2'd1;
            lives         <= 2'd3;
            score         <= 10'd0;
            timer         <= READY_T;
            timer_running <= 1'b0;
            done          <= 1'b0;
            sec_posedge   <= 1'b0;
            presc         <= '0;
            trig_s        <= 1'b0;
            trig_q        <= 1'b0;
            flag_s        <= 4'd0;
        end else begin
            // flag is captured with trig so the code lines up with the edge.
            trig_s      <= trig;
            trig_q      <= trig_s;
            flag_s      <= flag;
            done        <= 1'b0;
            sec_posedge <= 1'b0;

            // Second tick first; a timer-loading command below overrides it.
            if (timer_running) begin
                if (sec_wrap) begin
                    presc       <= '0;
                    sec_posedge <= 1'b1;
                    if (timer != 7'd0) begin
                        timer <= timer - 7'd1;
                    end else begin
                        timer_running <= 1'b0;
                    end
                end else begin
                    presc <= presc + PRESC_W'(1);
                end
            end else begin
                presc <= '0;
            end

            if (cmd_ok) begin
                done <= 1'b1;
                case (flag_s)
                    CMD_START: begin
                        timer_running <= 1'b1;
                        presc         <= '0;
                    end
                    CMD_PLAY: begin
                        st            <= ST_PLAYING;
                        timer         <= stage_time;
                        timer_running <= 1'b1;
                        presc         <= '0;
                    end
                    CMD_HIT: begin
                        score <= score_next;
                    end
                    CMD_MISS: begin
                        lives <= lives - 2'd1;
                    end
                    CMD_NEXT: begin
                        st            <= ST_STAGE_CLEAR;
                        timer_running <= 1'b0;
                        if (stage != 2'd3) begin
                            stage <= stage + 2'd1;
                        end
                    end
                    CMD_WIN: begin
                        st            <= ST_GAME_CLEAR;
                        timer_running <= 1'b0;
                    end
                    CMD_LOSE: begin
                        st            <= ST_GAME_OVER;
                        timer_running <= 1'b0;
                    end
                    CMD_BACK: begin
                        // Leaving a stage clear keeps progress; game end restarts.
                        if (st != ST_STAGE_CLEAR) begin
                            stage <= 2'd1;
                            lives <= 2'd3;
                            score <= 10'd0;
                        end
                        st            <= ST_READY;
                        timer         <= READY_T;
                        timer_running <= 1'b0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
